// File: rtl/sequence_checker.sv
// sequence_checker
//
// Generates the four-digit wire/button sequence for the sequence puzzle.
// It then checks the player's committed digits against that sequence.
// Digits are one-hot-low nibbles (4'b1110, 4'b1101, 4'b1011, 4'b0111).
// The sequence is taken from a free-running 8-bit LFSR at the moment the round is armed.
//
// Ports:
//   clk            system clock, rising edge
//   reset          asynchronous, active-low reset
//   arm            level-sampled request to generate a sequence and start entry
//   entry          player's current digit, one-hot-low
//   entry_commit   one-cycle strobe confirming entry for the current position
//   sequence_out   generated sequence, nibble i = digit i
//   sequence_valid sequence_out holds a generated sequence
//   position       index of the digit currently expected
//   strikes        mismatch count for the current round
//   strike         one-cycle pulse per mismatch
//   defused        all four digits entered correctly
//   exploded       strike limit reached
module sequence_checker #(
    parameter int MAX_STRIKES = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        arm,
    input  logic [3:0]  entry,
    input  logic        entry_commit,
    output logic [15:0] sequence_out,
    output logic        sequence_valid,
    output logic [1:0]  position,
    output logic [1:0]  strikes,
    output logic        strike,
    output logic        defused,
    output logic        exploded
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ENTRY,
        S_DONE,
        S_FAIL
    } state_t;

    localparam logic [1:0] MAX_S = 2'(MAX_STRIKES);

    state_t      state_q, state_d;
    logic [7:0]  lfsr_q, lfsr_d;
    logic [15:0] seq_q, seq_d;
    logic        valid_q, valid_d;
    logic [1:0]  pos_q, pos_d;
    logic [1:0]  strikes_q, strikes_d;
    logic        strike_q, strike_d;
    logic        defused_q, defused_d;
    logic        exploded_q, exploded_d;
    logic [3:0]  cur_digit;
    logic [1:0]  strikes_inc;

    // One-hot-low digit with the selected bit cleared.
    function automatic logic [3:0] digit_of(input logic [1:0] sel);
        return ~(4'b0001 << sel);
    endfunction

    function automatic logic [15:0] gen_sequence(input logic [7:0] r);
        return {digit_of(r[7:6]), digit_of(r[5:4]), digit_of(r[3:2]), digit_of(r[1:0])};
    endfunction

    always_comb begin
        case (pos_q)
            2'd0:    cur_digit = seq_q[3:0];
            2'd1:    cur_digit = seq_q[7:4];
            2'd2:    cur_digit = seq_q[11:8];
            default: cur_digit = seq_q[15:12];
        endcase
    end

    assign strikes_inc = strikes_q + 2'd1;

    always_comb begin
        state_d    = state_q;
        lfsr_d     = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        seq_d      = seq_q;
        valid_d    = valid_q;
        pos_d      = pos_q;
        strikes_d  = strikes_q;
        strike_d   = 1'b0;
        defused_d  = defused_q;
        exploded_d = exploded_q;

        case (state_q)
            S_IDLE: begin
                if (arm) begin
                    seq_d     = gen_sequence(lfsr_q);
                    valid_d   = 1'b1;
                    pos_d     = 2'd0;
                    strikes_d = 2'd0;
                    state_d   = S_ENTRY;
                end
            end
            S_ENTRY: begin
                // arm is deliberately not looked at here; only commits matter.
                if (entry_commit) begin
                    // A non-one-hot-low entry can never equal a generated digit,
                    // so it falls through to the mismatch path.
                    if (entry == cur_digit) begin
                        if (pos_q == 2'd3) begin
                            defused_d = 1'b1;
                            state_d   = S_DONE;
                        end else begin
                            pos_d = pos_q + 2'd1;
                        end
                    end else begin
                        strike_d  = 1'b1;
                        strikes_d = strikes_inc;
                        pos_d     = 2'd0;
                        if (strikes_inc == MAX_S) begin
                            exploded_d = 1'b1;
                            state_d    = S_FAIL;
                        end
                    end
                end
            end
            S_DONE, S_FAIL: begin
                if (arm) begin
                    seq_d      = gen_sequence(lfsr_q);
                    valid_d    = 1'b1;
                    pos_d      = 2'd0;
                    strikes_d  = 2'd0;
                    defused_d  = 1'b0;
                    exploded_d = 1'b0;
                    state_d    = S_ENTRY;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            lfsr_q     <= 8'hA5;
            seq_q      <= 16'h0000;
            valid_q    <= 1'b0;
            pos_q      <= 2'd0;
            strikes_q  <= 2'd0;
            strike_q   <= 1'b0;
            defused_q  <= 1'b0;
            exploded_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            lfsr_q     <= lfsr_d;
            seq_q      <= seq_d;
            valid_q    <= valid_d;
            pos_q      <= pos_d;
            strikes_q  <= strikes_d;
            strike_q   <= strike_d;
            defused_q  <= defused_d;
            exploded_q <= exploded_d;
        end
    end

    assign sequence_out   = seq_q;
    assign sequence_valid = valid_q;
    assign position       = pos_q;
    assign strikes        = strikes_q;
    assign strike         = strike_q;
    assign defused        = defused_q;
    assign exploded       = exploded_q;

endmodule

// File: tb/tb_sequence_checker.sv
// Testbench for sequence_checker: directed commit sequences through generation, entry,
// mismatch, explode, re-arm and asynchronous reset.
module tb_sequence_checker;

    logic        clk;
    logic        reset;
    logic        arm;
    logic [3:0]  entry;
    logic        entry_commit;
    logic [15:0] sequence_out;
    logic        sequence_valid;
    logic [1:0]  position;
    logic [1:0]  strikes;
    logic        strike;
    logic        defused;
    logic        exploded;

    int n_cmp;
    int n_mis;

    logic [7:0]  lfsr_m;
    logic [15:0] exp_seq;

    sequence_checker #(.MAX_STRIKES(3)) dut (
        .clk            (clk),
        .reset          (reset),
        .arm            (arm),
        .entry          (entry),
        .entry_commit   (entry_commit),
        .sequence_out   (sequence_out),
        .sequence_valid (sequence_valid),
        .position       (position),
        .strikes        (strikes),
        .strike         (strike),
        .defused        (defused),
        .exploded       (exploded)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference LFSR, used to predict the sequences loaded on later re-arms.
    always @(posedge clk or negedge reset) begin
        if (!reset) lfsr_m <= 8'hA5;
        else        lfsr_m <= {lfsr_m[6:0], lfsr_m[7] ^ lfsr_m[5] ^ lfsr_m[4] ^ lfsr_m[3]};
    end

    function automatic logic [3:0] ref_digit(input logic [1:0] sel);
        logic [3:0] d;
        d = 4'b1111;
        d[sel] = 1'b0;
        return d;
    endfunction

    function automatic logic [15:0] ref_seq(input logic [7:0] r);
        return {ref_digit(r[7:6]), ref_digit(r[5:4]), ref_digit(r[3:2]), ref_digit(r[1:0])};
    endfunction

    function automatic logic [3:0] bad_digit(input logic [3:0] d);
        return (d == 4'b0111) ? 4'b1110 : 4'b0111;
    endfunction

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input logic [15:0] seq, input logic vld,
                             input logic [1:0] pos, input logic [1:0] stk, input logic spulse,
                             input logic dfs, input logic exp_l);
        check_eq({tag, ".seq"},      sequence_out,          seq);
        check_eq({tag, ".valid"},    16'(sequence_valid),   16'(vld));
        check_eq({tag, ".pos"},      16'(position),         16'(pos));
        check_eq({tag, ".strikes"},  16'(strikes),          16'(stk));
        check_eq({tag, ".strike"},   16'(strike),           16'(spulse));
        check_eq({tag, ".defused"},  16'(defused),          16'(dfs));
        check_eq({tag, ".exploded"}, 16'(exploded),         16'(exp_l));
    endtask

    initial begin
        n_cmp        = 0;
        n_mis        = 0;
        reset        = 1'b0;
        arm          = 1'b0;
        entry        = 4'b1111;
        entry_commit = 1'b0;
        exp_seq      = 16'h0000;

        #12;
        check_all("reset", 16'h0000, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0);

        // Deterministic generation: arm in the first cycle after release.
        #1 reset = 1'b1;
        arm = 1'b1;
        step();
        arm = 1'b0;
        check_all("gen", 16'hBBDD, 1'b1, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0);

        // Correct entry, back-to-back commits.
        entry_commit = 1'b1;
        entry = 4'b1101; step();
        check_all("ok1", 16'hBBDD, 1'b1, 2'd1, 2'd0, 1'b0, 1'b0, 1'b0);
        entry = 4'b1101; step();
        check_all("ok2", 16'hBBDD, 1'b1, 2'd2, 2'd0, 1'b0, 1'b0, 1'b0);
        entry = 4'b1011; step();
        check_all("ok3", 16'hBBDD, 1'b1, 2'd3, 2'd0, 1'b0, 1'b0, 1'b0);
        entry = 4'b1011; step();
        check_all("ok4", 16'hBBDD, 1'b1, 2'd3, 2'd0, 1'b0, 1'b1, 1'b0);

        // DONE ignores commits.
        entry = 4'b0111; step();
        check_all("done_hold", 16'hBBDD, 1'b1, 2'd3, 2'd0, 1'b0, 1'b1, 1'b0);
        entry_commit = 1'b0;

        // Re-arm from DONE.
        arm = 1'b1;
        exp_seq = ref_seq(lfsr_m);
        step();
        arm = 1'b0;
        check_all("rearm_done", exp_seq, 1'b1, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0);

        // Mismatch at position 2.
        entry_commit = 1'b1;
        entry = exp_seq[3:0];  step();
        check_eq("mm_pos1", 16'(position), 16'd1);
        entry = exp_seq[7:4];  step();
        check_eq("mm_pos2", 16'(position), 16'd2);
        entry = bad_digit(exp_seq[11:8]); step();
        check_all("mismatch", exp_seq, 1'b1, 2'd0, 2'd1, 1'b1, 1'b0, 1'b0);
        entry_commit = 1'b0;
        step();
        check_all("strike_end", exp_seq, 1'b1, 2'd0, 2'd1, 1'b0, 1'b0, 1'b0);

        // arm coincident with a correct commit in ENTRY.
        arm = 1'b1;
        entry_commit = 1'b1;
        entry = exp_seq[3:0]; step();
        arm = 1'b0;
        check_all("arm_in_entry", exp_seq, 1'b1, 2'd1, 2'd1, 1'b0, 1'b0, 1'b0);
        entry = exp_seq[7:4]; step();
        entry_commit = 1'b0;
        check_all("pre_reset", exp_seq, 1'b1, 2'd2, 2'd1, 1'b0, 1'b0, 1'b0);

        // Asynchronous reset between edges.
        #2 reset = 1'b0;
        #1 check_all("async_reset", 16'h0000, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0);
        #1 reset = 1'b1;
        arm = 1'b1;
        step();
        arm = 1'b0;
        check_all("gen_after_reset", 16'hBBDD, 1'b1, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0);

        // Explode with three mismatches, one of them a non-one-hot entry.
        entry_commit = 1'b1;
        entry = 4'b0111; step();
        check_all("x1", 16'hBBDD, 1'b1, 2'd0, 2'd1, 1'b1, 1'b0, 1'b0);
        entry = 4'b0000; step();
        check_all("x2", 16'hBBDD, 1'b1, 2'd0, 2'd2, 1'b1, 1'b0, 1'b0);
        entry = 4'b1110; step();
        check_all("x3", 16'hBBDD, 1'b1, 2'd0, 2'd3, 1'b1, 1'b0, 1'b1);
        entry = 4'b1101; step();
        check_all("fail_hold1", 16'hBBDD, 1'b1, 2'd0, 2'd3, 1'b0, 1'b0, 1'b1);
        entry = 4'b0111; step();
        check_all("fail_hold2", 16'hBBDD, 1'b1, 2'd0, 2'd3, 1'b0, 1'b0, 1'b1);
        entry_commit = 1'b0;

        // Re-arm from FAIL with arm held high: loads once, then ignored in ENTRY.
        arm = 1'b1;
        exp_seq = ref_seq(lfsr_m);
        step();
        check_all("rearm_fail", exp_seq, 1'b1, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0);
        step();
        arm = 1'b0;
        check_all("arm_held", exp_seq, 1'b1, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
